// File: rtl/mpc_seq_pkg.sv
// Shared types and helpers for the MPC sample sequencer: FSM state encoding,
// default data width and the signed saturation used on the inference result.
package mpc_seq_pkg;

    localparam int DEF_DATA_W = 18;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } seq_state_t;

    function automatic logic signed [DEF_DATA_W-1:0] sat_clamp(
        input logic signed [DEF_DATA_W-1:0] x,
        input logic signed [DEF_DATA_W-1:0] lo,
        input logic signed [DEF_DATA_W-1:0] hi
    );
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/mpc_period_timer.sv
// Control-period timer: counts 0..PERIOD-1 while i_ce is high and emits a
// registered one-cycle o_tick in the cycle the count has wrapped back to 0.
module mpc_period_timer #(
    parameter int PERIOD = 1000
) (
    input  logic clk_1,
    input  logic ap_rst,
    input  logic i_ce,
    output logic o_tick
);

    localparam int CW = $clog2(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    always_ff @(posedge clk_1 or posedge ap_rst) begin
        if (ap_rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= i_ce && (r_cnt == LAST);
            if (i_ce)
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/mpc_sample_sequencer.sv
// Control-loop sequencer around the NN inference core: snapshot, launch,
// saturated capture, overrun detection. Optional WAIT watchdog: SEQ_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a period tick; snapshot latched on tick
// LAUNCH | one cycle; nn_start/nn_in_vld issued on the following cycle
// WAIT   | inference running; capture result, exit on nn_done (or watchdog)
module mpc_sample_sequencer
    import mpc_seq_pkg::*;
#(
    parameter int                       DATA_W  = DEF_DATA_W,
    parameter int                       PERIOD  = 1000,
    parameter int                       TIMEOUT = 800,
    parameter logic signed [DATA_W-1:0] U_MAX   = 18'sh0FFFF,
    parameter logic signed [DATA_W-1:0] U_MIN   = -18'sh0FFFF,
    parameter int                       CNT_W   = 16
) (
    input  logic                     clk_1,
    input  logic                     ap_rst,
    input  logic                     ce_1,
    input  logic                     clear_flags,
    input  logic        [DATA_W-1:0] r_in,
    input  logic        [DATA_W-1:0] pos_in,
    input  logic        [DATA_W-1:0] vel_in,
    output logic        [DATA_W-1:0] nn_r,
    output logic        [DATA_W-1:0] nn_pos,
    output logic        [DATA_W-1:0] nn_vel,
    output logic                     nn_start,
    output logic                     nn_in_vld,
    input  logic                     nn_done,
    input  logic signed [DATA_W-1:0] nn_out,
    input  logic                     nn_out_vld,
    output logic signed [DATA_W-1:0] u_out,
    output logic                     u_valid,
    output logic                     busy,
    output logic                     overrun,
    output logic                     timeout,
    output logic        [7:0]        overrun_cnt,
    output logic        [CNT_W-1:0]  sample_cnt
);

    seq_state_t               r_state, w_next;
    logic                     w_tick, w_launch, w_busy, w_in_wait;
    logic                     w_done_ok, w_accept, w_drop, w_capture, w_timeout_hit;
    logic        [DATA_W-1:0] r_nn_r, r_nn_pos, r_nn_vel;
    logic                     r_nn_start, r_nn_in_vld;
    logic                     r_vld_d, r_rise, r_captured;
    logic signed [DATA_W-1:0] r_out_d, r_u_out;
    logic                     r_u_valid, r_overrun;
    logic        [7:0]        r_overrun_cnt;
    logic        [CNT_W-1:0]  r_sample_cnt;

    mpc_period_timer #(.PERIOD(PERIOD)) u_timer (
        .clk_1  (clk_1),
        .ap_rst (ap_rst),
        .i_ce   (ce_1),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk_1 or posedge ap_rst) begin
        if (ap_rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_tick) w_next = LAUNCH;
            LAUNCH:  w_next = WAIT;
            WAIT: begin
                if (nn_done)
                    w_next = w_tick ? LAUNCH : IDLE;
                else if (w_timeout_hit)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_launch  = 1'b0;
        w_busy    = 1'b0;
        w_in_wait = 1'b0;
        case (r_state)
            LAUNCH: begin
                w_launch = 1'b1;
                w_busy   = 1'b1;
            end
            WAIT: begin
                w_busy    = 1'b1;
                w_in_wait = 1'b1;
            end
            default: ;
        endcase
    end

    // A tick coinciding with nn_done is a clean hand-over, not an overrun.
    assign w_done_ok = w_in_wait && nn_done;
    assign w_accept  = w_tick && (!w_busy || w_done_ok);
    assign w_drop    = w_tick && w_busy && !w_done_ok;
    assign w_capture = w_in_wait && r_rise && !r_captured;

    always_ff @(posedge clk_1 or posedge ap_rst) begin
        if (ap_rst) begin
            r_nn_r        <= '0;
            r_nn_pos      <= '0;
            r_nn_vel      <= '0;
            r_nn_start    <= 1'b0;
            r_nn_in_vld   <= 1'b0;
            r_vld_d       <= 1'b0;
            r_rise        <= 1'b0;
            r_out_d       <= '0;
            r_captured    <= 1'b0;
            r_u_out       <= '0;
            r_u_valid     <= 1'b0;
            r_overrun     <= 1'b0;
            r_overrun_cnt <= '0;
            r_sample_cnt  <= '0;
        end else begin
            r_nn_start  <= w_launch;
            r_nn_in_vld <= w_launch;
            r_vld_d     <= nn_out_vld;
            r_rise      <= nn_out_vld && !r_vld_d;
            r_out_d     <= nn_out;
            r_u_valid   <= w_capture;
            if (w_accept) begin
                r_nn_r   <= r_in;
                r_nn_pos <= pos_in;
                r_nn_vel <= vel_in;
            end
            if (w_capture)
                r_u_out <= sat_clamp(r_out_d, U_MIN, U_MAX);
            if (w_launch)
                r_captured <= 1'b0;
            else if (w_capture)
                r_captured <= 1'b1;
            if (w_done_ok && (r_captured || w_capture))
                r_sample_cnt <= r_sample_cnt + 1'b1;
            if (w_drop) begin
                r_overrun     <= 1'b1;
                r_overrun_cnt <= clear_flags ? 8'd1 :
                                 (r_overrun_cnt == 8'hFF) ? 8'hFF : r_overrun_cnt + 8'd1;
            end else if (clear_flags) begin
                r_overrun     <= 1'b0;
                r_overrun_cnt <= '0;
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_wait_cnt;
    logic          r_timeout;

    assign w_timeout_hit = w_in_wait && (r_wait_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_1 or posedge ap_rst) begin
        if (ap_rst) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (!w_in_wait)
                r_wait_cnt <= '0;
            else if (!w_timeout_hit)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            if (w_timeout_hit && !nn_done)
                r_timeout <= 1'b1;
            else if (clear_flags)
                r_timeout <= 1'b0;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign timeout       = 1'b0;
`endif

    assign nn_r        = r_nn_r;
    assign nn_pos      = r_nn_pos;
    assign nn_vel      = r_nn_vel;
    assign nn_start    = r_nn_start;
    assign nn_in_vld   = r_nn_in_vld;
    assign u_out       = r_u_out;
    assign u_valid     = r_u_valid;
    assign busy        = w_busy;
    assign overrun     = r_overrun;
    assign overrun_cnt = r_overrun_cnt;
    assign sample_cnt  = r_sample_cnt;

endmodule

// File: tb/tb_mpc_sample_sequencer.sv
// Directed bench for mpc_sample_sequencer with PERIOD=100, TIMEOUT=50.
// Edge index e counts rising clk_1 edges since reset release; first tick follows edge 100.
`timescale 1ns/1ps
module tb_mpc_sample_sequencer;

    logic               clk_1 = 1'b0;
    logic               ap_rst = 1'b1;
    logic               ce_1 = 1'b1;
    logic               clear_flags = 1'b0;
    logic [17:0]        r_in = '0, pos_in = '0, vel_in = '0;
    logic [17:0]        nn_r, nn_pos, nn_vel;
    logic               nn_start, nn_in_vld;
    logic               nn_done = 1'b0;
    logic signed [17:0] nn_out = '0;
    logic               nn_out_vld = 1'b0;
    logic signed [17:0] u_out;
    logic               u_valid, busy, overrun, timeout;
    logic [7:0]         overrun_cnt;
    logic [15:0]        sample_cnt;

    int errors = 0;
    int checks = 0;
    int e = 0;

    mpc_sample_sequencer #(
        .DATA_W(18), .PERIOD(100), .TIMEOUT(50),
        .U_MAX(18'sh0FFFF), .U_MIN(-18'sh0FFFF), .CNT_W(16)
    ) u_dut (
        .clk_1(clk_1), .ap_rst(ap_rst), .ce_1(ce_1), .clear_flags(clear_flags),
        .r_in(r_in), .pos_in(pos_in), .vel_in(vel_in),
        .nn_r(nn_r), .nn_pos(nn_pos), .nn_vel(nn_vel),
        .nn_start(nn_start), .nn_in_vld(nn_in_vld),
        .nn_done(nn_done), .nn_out(nn_out), .nn_out_vld(nn_out_vld),
        .u_out(u_out), .u_valid(u_valid), .busy(busy),
        .overrun(overrun), .timeout(timeout),
        .overrun_cnt(overrun_cnt), .sample_cnt(sample_cnt)
    );

    always #5 clk_1 = ~clk_1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_1);
        #1;
        e = e + 1;
    endtask

    task automatic go_to(input int n);
        while (e < n) step();
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        nn_done = 1'b0;
        nn_out_vld = 1'b0;
        clear_flags = 1'b0;
        ce_1 = 1'b1;
        @(posedge clk_1); #1;
        @(posedge clk_1); #1;
        ap_rst = 1'b0;
        e = 0;
    endtask

    task automatic wait_start(input int exp_e, input string name);
        int lim;
        lim = e + 400;
        while (nn_start !== 1'b1 && e < lim) step();
        checks++;
        if (nn_start !== 1'b1 || nn_in_vld !== 1'b1 || e != exp_e) begin
            errors++;
            $display("FAIL %s: nn_start=%b nn_in_vld=%b at edge %0d, expected both 1 at edge %0d",
                     name, nn_start, nn_in_vld, e, exp_e);
        end
    endtask

    task automatic test_reset();
        r_in = 18'd9; pos_in = 18'd9; vel_in = 18'd9;
        do_reset();
        checks++;
        if (nn_r !== 0 || nn_pos !== 0 || nn_vel !== 0 || nn_start !== 0 || nn_in_vld !== 0) begin
            errors++;
            $display("FAIL reset_nn: r=%h pos=%h vel=%h start=%b vld=%b, expected all 0",
                     nn_r, nn_pos, nn_vel, nn_start, nn_in_vld);
        end
        checks++;
        if (u_out !== 0 || u_valid !== 0 || busy !== 0 || overrun !== 0 || timeout !== 0 ||
            overrun_cnt !== 0 || sample_cnt !== 0) begin
            errors++;
            $display("FAIL reset_status: u=%h uv=%b busy=%b ovr=%b to=%b ocnt=%0d scnt=%0d, expected all 0",
                     u_out, u_valid, busy, overrun, timeout, overrun_cnt, sample_cnt);
        end
    endtask

    task automatic test_ce_freeze();
        do_reset();
        ce_1 = 1'b0;
        go_to(10);
        ce_1 = 1'b1;
        go_to(101);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ce_freeze_busy: busy=%b at edge 101, expected 0", busy);
        end
        wait_start(112, "ce_freeze_start");
    endtask

    task automatic test_snapshot();
        do_reset();
        r_in = 18'd5; pos_in = -18'sd3; vel_in = 18'd7;
        go_to(101);
        r_in = 18'd99; pos_in = 18'd98; vel_in = 18'd97;
        wait_start(102, "snapshot_start");
        step();
        checks++;
        if (nn_start !== 1'b0 || nn_in_vld !== 1'b0) begin
            errors++;
            $display("FAIL start_pulse: nn_start=%b nn_in_vld=%b one cycle later, expected 0",
                     nn_start, nn_in_vld);
        end
        go_to(130);
        checks++;
        if (nn_r !== 18'd5 || nn_pos !== 18'h3FFFD || nn_vel !== 18'd7) begin
            errors++;
            $display("FAIL snapshot_hold: r=%h pos=%h vel=%h, expected 00005 3fffd 00007",
                     nn_r, nn_pos, nn_vel);
        end
        nn_done = 1'b1;
        step();
        nn_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || sample_cnt !== 16'd0 || u_out !== 18'sd0 || u_valid !== 1'b0) begin
            errors++;
            $display("FAIL missing_result: busy=%b scnt=%0d u=%h uv=%b, expected 0 0 0 0",
                     busy, sample_cnt, u_out, u_valid);
        end
    endtask

    task automatic test_capture_high();
        int pulses;
        do_reset();
        wait_start(102, "cap_hi_start");
        nn_out = 18'sh1FFFF;
        nn_out_vld = 1'b1;
        pulses = 0;
        while (e < 110) begin
            step();
            if (u_valid === 1'b1) pulses++;
            if (e == 104) begin
                checks++;
                if (u_valid !== 1'b1 || u_out !== 18'sh0FFFF) begin
                    errors++;
                    $display("FAIL cap_hi_latency: at edge 104 uv=%b u=%h, expected 1 0ffff", u_valid, u_out);
                end
                nn_out_vld = 1'b0;
            end
            if (e == 106) begin
                nn_out = 18'sh00100;
                nn_out_vld = 1'b1;
            end
            if (e == 108) nn_out_vld = 1'b0;
        end
        checks++;
        if (pulses != 1 || u_out !== 18'sh0FFFF) begin
            errors++;
            $display("FAIL cap_hi_once: u_valid pulses=%0d u=%h, expected 1 0ffff", pulses, u_out);
        end
        checks++;
        if (sample_cnt !== 16'd0) begin
            errors++;
            $display("FAIL cap_hi_cnt_before: sample_cnt=%0d, expected 0", sample_cnt);
        end
        nn_done = 1'b1;
        step();
        nn_done = 1'b0;
        checks++;
        if (sample_cnt !== 16'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cap_hi_done: sample_cnt=%0d busy=%b, expected 1 0", sample_cnt, busy);
        end
    endtask

    task automatic test_clamp_low();
        do_reset();
        wait_start(102, "cap_lo_start");
        nn_out = 18'sh20000;
        nn_out_vld = 1'b1;
        go_to(104);
        nn_out_vld = 1'b0;
        checks++;
        if (u_valid !== 1'b1 || u_out !== 18'sh30001) begin
            errors++;
            $display("FAIL cap_lo: uv=%b u=%h, expected 1 30001", u_valid, u_out);
        end
        step();
        checks++;
        if (u_valid !== 1'b0) begin
            errors++;
            $display("FAIL cap_lo_pulse: uv=%b one cycle later, expected 0", u_valid);
        end
    endtask

`ifndef SEQ_TIMEOUT_EN
    task automatic test_tick_done_same();
        do_reset();
        wait_start(102, "same_start1");
        nn_out = 18'sh00100;
        nn_out_vld = 1'b1;
        go_to(104);
        nn_out_vld = 1'b0;
        checks++;
        if (u_out !== 18'sh00100) begin
            errors++;
            $display("FAIL pass_through: u=%h, expected 00100", u_out);
        end
        go_to(200);
        nn_done = 1'b1;
        step();
        nn_done = 1'b0;
        checks++;
        if (busy !== 1'b1 || nn_start !== 1'b0 || sample_cnt !== 16'd1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL same_201: busy=%b start=%b scnt=%0d ovr=%b, expected 1 0 1 0",
                     busy, nn_start, sample_cnt, overrun);
        end
        step();
        checks++;
        if (nn_start !== 1'b1 || overrun !== 1'b0 || overrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL same_202: start=%b ovr=%b ocnt=%0d, expected 1 0 0", nn_start, overrun, overrun_cnt);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        wait_start(102, "ovr_start");
        go_to(200);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_pre: overrun=%b at edge 200, expected 0", overrun);
        end
        step();
        checks++;
        if (overrun !== 1'b1 || overrun_cnt !== 8'd1) begin
            errors++;
            $display("FAIL ovr_first: ovr=%b ocnt=%0d, expected 1 1", overrun, overrun_cnt);
        end
        go_to(301);
        checks++;
        if (overrun_cnt !== 8'd2) begin
            errors++;
            $display("FAIL ovr_second: ocnt=%0d, expected 2", overrun_cnt);
        end
        go_to(310);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        checks++;
        if (overrun !== 1'b0 || overrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL ovr_clear: ovr=%b ocnt=%0d, expected 0 0", overrun, overrun_cnt);
        end
        go_to(400);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        checks++;
        if (overrun !== 1'b1 || overrun_cnt !== 8'd1) begin
            errors++;
            $display("FAIL ovr_set_wins: ovr=%b ocnt=%0d, expected 1 1", overrun, overrun_cnt);
        end
        go_to(405);
        nn_done = 1'b1;
        step();
        nn_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || sample_cnt !== 16'd0 || u_out !== 18'sd0) begin
            errors++;
            $display("FAIL ovr_done: busy=%b scnt=%0d u=%h, expected 0 0 0", busy, sample_cnt, u_out);
        end
        wait_start(502, "ovr_restart");
    endtask
`else
    task automatic test_timeout();
        do_reset();
        wait_start(102, "to_start");
        go_to(151);
        checks++;
        if (busy !== 1'b1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_pre: busy=%b timeout=%b at edge 151, expected 1 0", busy, timeout);
        end
        step();
        checks++;
        if (busy !== 1'b0 || timeout !== 1'b1 || u_out !== 18'sd0 || u_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_hit: busy=%b to=%b u=%h uv=%b, expected 0 1 0 0", busy, timeout, u_out, u_valid);
        end
        go_to(160);
        nn_done = 1'b1;
        nn_out = 18'sh00123;
        nn_out_vld = 1'b1;
        step();
        nn_done = 1'b0;
        step();
        nn_out_vld = 1'b0;
        go_to(166);
        checks++;
        if (busy !== 1'b0 || sample_cnt !== 16'd0 || u_out !== 18'sd0) begin
            errors++;
            $display("FAIL to_late: busy=%b scnt=%0d u=%h, expected 0 0 0", busy, sample_cnt, u_out);
        end
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_clear: timeout=%b, expected 0", timeout);
        end
    endtask
`endif

    task automatic test_async_reset();
        int uv_seen;
        do_reset();
        r_in = 18'd5;
        wait_start(102, "ar_start1");
        nn_out = 18'sh1FFFF;
        nn_out_vld = 1'b1;
        go_to(104);
        nn_out_vld = 1'b0;
        go_to(110);
        nn_done = 1'b1;
        step();
        nn_done = 1'b0;
        wait_start(202, "ar_start2");
        nn_out = 18'sh00100;
        nn_out_vld = 1'b1;
        step();
        ap_rst = 1'b1;
        #2;
        checks++;
        if (u_out !== 18'sd0 || sample_cnt !== 16'd0 || busy !== 1'b0 || nn_r !== 18'd0) begin
            errors++;
            $display("FAIL async_reset: u=%h scnt=%0d busy=%b nn_r=%h, expected 0 0 0 0",
                     u_out, sample_cnt, busy, nn_r);
        end
        nn_out_vld = 1'b0;
        @(posedge clk_1); #1;
        ap_rst = 1'b0;
        e = 0;
        uv_seen = 0;
        while (e < 6) begin
            step();
            if (u_valid === 1'b1) uv_seen++;
        end
        checks++;
        if (uv_seen != 0 || u_out !== 18'sd0) begin
            errors++;
            $display("FAIL async_discard: u_valid pulses=%0d u=%h, expected 0 0", uv_seen, u_out);
        end
    endtask

    initial begin
        test_reset();
        test_ce_freeze();
        test_snapshot();
        test_capture_high();
        test_clamp_low();
`ifndef SEQ_TIMEOUT_EN
        test_tick_done_same();
        test_overrun();
`else
        test_timeout();
`endif
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
